ram_burst_model: RTL
====================

# ram_burst_model

Behavioural main-memory model that sits directly downstream of the cache's memory interface and answers its line read/write requests. Cache lines cross a narrow data bus as a burst of beats, least-significant beat first. A fixed access latency models DRAM delay. Completion is signalled by a one-cycle ACK pulse.

## Interface

- LINE_W, 32, cache line width in bits; must be a multiple of BUS_W.
- BUS_W, 8, data bus width per beat.
- ADDR_W, 8, line address width; array depth is 2**ADDR_W lines.
- LATENCY, 3, access delay in cycles; must be ≥1.

Ports (BEATS = LINE_W/BUS_W):

- CLK  in  1  clock, all logic on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- SIG_RD  in  1  read-line request, sampled only in IDLE.
- SIG_WR  in  1  write-line request, sampled only in IDLE.
- IN_ADDR  in  ADDR_W  line address, sampled with the request.
- IN_BUS  in  BUS_W  write beat data.
- IN_BUS_VALID  in  1  write beat qualifier.
- OUT_BUS  out  BUS_W  read beat data; 0 when OUT_BUS_VALID=0.
- OUT_BUS_VALID  out  1  read beat qualifier.
- BUSY  out  1  high in every state except IDLE.
- ACK  out  1  one-cycle completion pulse.
- OUT_ERR  out  1  one-cycle pulse on an illegal request.

## Operation

- States: IDLE, WR_BURST, WAIT, RD_BURST, DONE.
- Internal registers:
  - address latch;
  - LINE_W assembly/shift register;
  - beat counter, clog2(BEATS)+1 bits;
  - latency counter, clog2(LATENCY)+1 bits;
  - direction flag.
- IDLE, decided on the sampled inputs:
  - SIG_RD=1, SIG_WR=0: latch IN_ADDR, load the latency counter, go to WAIT (read).
  - SIG_WR=1, SIG_RD=0: latch IN_ADDR, clear the beat counter, go to WR_BURST.
  - Both high: stay in IDLE, pulse OUT_ERR for the next cycle, leave the memory untouched.
  - Neither high: stay in IDLE.
- WR_BURST:
  - On each edge with IN_BUS_VALID=1, IN_BUS fills bits [k*BUS_W +: BUS_W] for beat k.
  - Cycles with IN_BUS_VALID=0 are stalls, of unbounded length.
  - At the edge accepting beat BEATS-1: load the latency counter, go to WAIT (write).
- WAIT: count down LATENCY cycles, then:
  - read: load the array line into the shift register, go to RD_BURST;
  - write: write the assembly register into the array, go to DONE.
- RD_BURST:
  - Lasts BEATS cycles; OUT_BUS_VALID=1, OUT_BUS = low BUS_W bits of the shift register.
  - Shift right by BUS_W each edge.
  - After the last beat, go to DONE.
- DONE: ACK=1 for exactly one cycle, then IDLE.
- SIG_RD/SIG_WR asserted while BUSY=1 are ignored; they are neither queued nor flagged.
- IN_BUS_VALID outside WR_BURST is ignored.
- Array contents:
  - zero at time 0 (simulation initialisation);
  - not cleared by RST.
- RST=1 at any edge:
  - state goes to IDLE, all counters clear;
  - a partial write burst is discarded and the array is unchanged;
  - an in-progress read is abandoned.

## Timing

- Reset values: OUT_BUS=0, OUT_BUS_VALID=0, BUSY=0, ACK=0, OUT_ERR=0. All outputs are registered.
- Read accepted at edge E0:
  - BUSY=1 from the cycle after E0;
  - beats valid in cycles E0+LATENCY+1 … E0+LATENCY+BEATS;
  - ACK in cycle E0+LATENCY+BEATS+1;
  - IDLE (BUSY=0) in cycle E0+LATENCY+BEATS+2, where a new request may be sampled.
- Write whose final beat is accepted at edge Ew:
  - array updated at edge Ew+LATENCY;
  - ACK in cycle Ew+LATENCY+1;
  - IDLE in cycle Ew+LATENCY+2.
- Minimum write with no stalls: first beat is presented in the cycle after E0, giving Ew=E0+BEATS.
- A read after a write to the same address, issued once IDLE resumes, returns the new data.

## Test plan

Parameters for all scenarios: defaults, so BEATS=4 and LATENCY=3.

- Reset: hold RST 2 cycles with SIG_RD=1 -> all outputs 0, BUSY=0, no ACK.
- Write then read: write addr 0x05 with beats EF,BE,AD,DE with no stalls, then read 0x05 -> OUT_BUS gives EF,BE,AD,DE in cycles E0+4…E0+7, ACK at E0+8, BUSY low at E0+9.
- Stalled write: write addr 0x10 with beats 11,22,33,44 and IN_BUS_VALID low for 2 cycles between each beat -> ACK 4 cycles after the last beat edge; read back gives 0x44332211.
- Illegal request: SIG_RD=SIG_WR=1 in IDLE -> OUT_ERR pulse 1 cycle, BUSY stays 0; subsequent read of addr 0x05 still returns 0xDEADBEEF.
- Reset mid-write: write addr 0x05 with data 0x12345678; assert RST after 2 beats -> IDLE next cycle, no ACK; read 0x05 returns 0xDEADBEEF.
- Ignored and unwritten requests:
  - SIG_WR pulsed while a read is BUSY -> no extra transaction, exactly one ACK;
  - read of never-written addr 0xFF -> four beats of 00.

Source files
------------

// File: rtl/ram_burst_model.sv
// rtl/ram_burst_model.sv - behavioural line-burst main memory behind the cache
//
// Purpose:
//   Answers cache line read/write requests. A line travels over the narrow
//   data bus as BEATS = LINE_W/BUS_W beats, least-significant beat first.
//   A fixed LATENCY-cycle wait models DRAM access time, and a one-cycle ACK
//   marks completion. All outputs are registered.
//
// Ports:
//   CLK            in   clock, rising edge
//   RST            in   synchronous active-high reset (array contents kept)
//   SIG_RD         in   read-line request, sampled only in IDLE
//   SIG_WR         in   write-line request, sampled only in IDLE
//   IN_ADDR        in   line address, sampled with the request
//   IN_BUS         in   write beat data
//   IN_BUS_VALID   in   write beat qualifier
//   OUT_BUS        out  read beat data, 0 when OUT_BUS_VALID is low
//   OUT_BUS_VALID  out  read beat qualifier
//   BUSY           out  high in every state except IDLE
//   ACK            out  one-cycle completion pulse
//   OUT_ERR        out  one-cycle pulse on a simultaneous read+write request

module ram_burst_model #(
  parameter int LINE_W  = 32,
  parameter int BUS_W   = 8,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SIG_RD,
  input  logic              SIG_WR,
  input  logic [ADDR_W-1:0] IN_ADDR,
  input  logic [BUS_W-1:0]  IN_BUS,
  input  logic              IN_BUS_VALID,
  output logic [BUS_W-1:0]  OUT_BUS,
  output logic              OUT_BUS_VALID,
  output logic              BUSY,
  output logic              ACK,
  output logic              OUT_ERR
);

  localparam int BEATS  = LINE_W / BUS_W;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int BCNT_W = $clog2(BEATS) + 1;
  localparam int LCNT_W = $clog2(LATENCY) + 1;

  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);
  // WAIT spends LATENCY cycles: the counter runs LATENCY-1 down to 0 and the
  // transition out of WAIT happens on the edge that sees zero.
  localparam logic [LCNT_W-1:0] LAT_LOAD  = LCNT_W'(LATENCY - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_BURST = 3'd1;
  localparam logic [2:0] S_WAIT     = 3'd2;
  localparam logic [2:0] S_RD_BURST = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] line_q;      // write assembly register, reused as read shifter
  logic [BCNT_W-1:0] beat_cnt;
  logic [LCNT_W-1:0] lat_cnt;
  logic              dir_rd;      // 1: read transaction, 0: write transaction

  // Zero-initialised storage; reset deliberately leaves it alone.
  logic [LINE_W-1:0] mem [0:DEPTH-1] = '{default: '0};

  logic [LINE_W-1:0] rd_line;
  logic [LINE_W-1:0] line_shift;
  logic              wait_done;
  logic              mem_we;

  assign rd_line    = mem[addr_q];
  assign line_shift = line_q >> BUS_W;
  assign wait_done  = (state == S_WAIT) && (lat_cnt == '0);
  assign mem_we     = !RST && wait_done && !dir_rd;

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[addr_q] <= line_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= S_IDLE;
      addr_q        <= '0;
      line_q        <= '0;
      beat_cnt      <= '0;
      lat_cnt       <= '0;
      dir_rd        <= 1'b0;
      OUT_BUS       <= '0;
      OUT_BUS_VALID <= 1'b0;
      BUSY          <= 1'b0;
      ACK           <= 1'b0;
      OUT_ERR       <= 1'b0;
    end else begin
      ACK     <= 1'b0;
      OUT_ERR <= 1'b0;

      case (state)
        S_IDLE: begin
          if (SIG_RD && !SIG_WR) begin
            addr_q  <= IN_ADDR;
            lat_cnt <= LAT_LOAD;
            dir_rd  <= 1'b1;
            BUSY    <= 1'b1;
            state   <= S_WAIT;
          end else if (SIG_WR && !SIG_RD) begin
            addr_q   <= IN_ADDR;
            beat_cnt <= '0;
            dir_rd   <= 1'b0;
            BUSY     <= 1'b1;
            state    <= S_WR_BURST;
          end else if (SIG_RD && SIG_WR) begin
            OUT_ERR <= 1'b1;
          end
        end

        S_WR_BURST: begin
          // Cycles without IN_BUS_VALID are stalls and simply hold position.
          if (IN_BUS_VALID) begin
            line_q[beat_cnt*BUS_W +: BUS_W] <= IN_BUS;
            if (beat_cnt == LAST_BEAT) begin
              lat_cnt <= LAT_LOAD;
              state   <= S_WAIT;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end

        S_WAIT: begin
          if (!wait_done) begin
            lat_cnt <= lat_cnt - 1'b1;
          end else if (dir_rd) begin
            // First beat is presented in the same cycle RD_BURST begins.
            line_q        <= rd_line;
            OUT_BUS       <= rd_line[BUS_W-1:0];
            OUT_BUS_VALID <= 1'b1;
            beat_cnt      <= '0;
            state         <= S_RD_BURST;
          end else begin
            ACK   <= 1'b1;
            state <= S_DONE;
          end
        end

        S_RD_BURST: begin
          line_q <= line_shift;
          if (beat_cnt == LAST_BEAT) begin
            OUT_BUS       <= '0;
            OUT_BUS_VALID <= 1'b0;
            ACK           <= 1'b1;
            state         <= S_DONE;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
            OUT_BUS  <= line_shift[BUS_W-1:0];
          end
        end

        S_DONE: begin
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          OUT_BUS       <= '0;
          OUT_BUS_VALID <= 1'b0;
          BUSY          <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule
